// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding selects, load-use stall,
// branch flushes and data-memory wait/timeout freeze. Optional counters: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MemTimeoutErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] LwStallCnt,
    output logic [31:0] MemStallCnt,
    output logic [31:0] FlushCnt
`endif
);

    // state | meaning
    // RUN   | pipeline flowing, no outstanding memory hold-off
    // MWAIT | M-stage access waiting for MemReadyM, cnt = cycles waited
    // ERR   | memory never answered; pipeline frozen until reset

    typedef enum logic [1:0] {RUN, MWAIT, ERR} stateT;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             memStall;
    logic             err;
    logic             lwStall;
    logic             hold;
    logic [1:0]       fwdA, fwdB;
    logic             stallFD, flushDRaw, flushERaw;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       wrM,
        input logic [4:0] rdW,
        input logic       wrW
    );
        if (wrM && rdM != 5'd0 && rdM == rs) return 2'b10;
        else if (wrW && rdW != 5'd0 && rdW == rs) return 2'b01;
        else return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        memStall  = 1'b0;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    stateNext = MWAIT;
                    cntNext   = CNT_W'(1);
                    memStall  = 1'b1;
                end else begin
                    cntNext = '0;
                end
            end
            MWAIT: begin
                if (MemReadyM) begin
                    stateNext = RUN;
                    cntNext   = '0;
                end else begin
                    memStall = 1'b1;
                    if (cnt == CNT_LAST) stateNext = ERR;
                    else cntNext = cnt + CNT_W'(1);
                end
            end
            ERR: stateNext = ERR;
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase
    end

    assign err       = (state == ERR);
    assign fwdA      = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign fwdB      = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign lwStall   = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign hold      = memStall || err;
    assign stallFD   = lwStall || hold;
    // A frozen pipeline must not flush: the branch is re-evaluated after release.
    assign flushERaw = (lwStall || PCSrcE) && !hold;
    assign flushDRaw = PCSrcE && !hold;

    // Outputs are forced low for the whole time reset is asserted.
    assign ForwardAE     = rst ? fwdA : 2'b00;
    assign ForwardBE     = rst ? fwdB : 2'b00;
    assign StallF        = rst && stallFD;
    assign StallD        = rst && stallFD;
    assign StallE        = rst && hold;
    assign StallM        = rst && hold;
    assign StallW        = rst && hold;
    assign FlushD        = rst && flushDRaw;
    assign FlushE        = rst && flushERaw;
    assign MemTimeoutErr = rst && err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lwCnt, memCnt, flCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lwCnt  <= '0;
            memCnt <= '0;
            flCnt  <= '0;
        end else begin
            if (lwStall && !hold && lwCnt != 32'hFFFF_FFFF) lwCnt <= lwCnt + 32'd1;
            if (hold && memCnt != 32'hFFFF_FFFF) memCnt <= memCnt + 32'd1;
            if (flushDRaw && flCnt != 32'hFFFF_FFFF) flCnt <= flCnt + 32'd1;
        end
    end

    assign LwStallCnt  = lwCnt;
    assign MemStallCnt = memCnt;
    assign FlushCnt    = flCnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl, built with TIMEOUT=4.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemTimeoutErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] LwStallCnt, MemStallCnt, FlushCnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] expQ[$];
    logic [11:0] obs;
    logic [11:0] e;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .MemTimeoutErr(MemTimeoutErr)
`ifdef HAZARD_PERF_CNT_EN
        , .LwStallCnt(LwStallCnt), .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
`endif
    );

    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
                  FlushD, FlushE, MemTimeoutErr};

    // Expected output vector: fwdA, fwdB, StallF/D, StallE/M/W, FlushD, FlushE, err.
    function automatic logic [11:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sfd, input logic hd,
                                       input logic fd, input logic fe, input logic er);
        return {fa, fb, sfd, sfd, hd, hd, hd, fd, fe, er};
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        RegWriteM = 1; RdM = 5; Rs1E = 5; MemReqM = 1; PCSrcE = 1;
        expQ.push_back(12'd0);
        @(negedge clk);
        e = expQ.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, e); end
        nextCycle();
        rst = 1;
        idle();
        expQ.push_back(12'd0);
        @(negedge clk);
        e = expQ.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release got %b want %b", obs, e); end
        nextCycle();
    endtask

    task automatic test_forward();
        for (int i = 0; i < 7; i++) begin
            idle();
            case (i)
                0: begin RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1; expQ.push_back(ex(2'b10, 2'b00, 0, 0, 0, 0, 0)); end
                1: begin RdM = 5; RdW = 5; Rs1E = 5; RegWriteW = 1; expQ.push_back(ex(2'b01, 2'b00, 0, 0, 0, 0, 0)); end
                2: begin RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; expQ.push_back(ex(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
                3: begin RegWriteM = 1; RegWriteW = 1; expQ.push_back(ex(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
                4: begin RdM = 9; RdW = 9; Rs1E = 9; Rs2E = 9; RegWriteM = 1; RegWriteW = 1; expQ.push_back(ex(2'b10, 2'b10, 0, 0, 0, 0, 0)); end
                5: begin RdM = 8; Rs1E = 8; RdW = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1; expQ.push_back(ex(2'b10, 2'b01, 0, 0, 0, 0, 0)); end
                default: begin RdM = 8; Rs1E = 8; RdW = 7; Rs2E = 7; RegWriteM = 1; expQ.push_back(ex(2'b10, 2'b00, 0, 0, 0, 0, 0)); end
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL forward_case%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin ResultSrcE0 = 1; RdE = 3; Rs2D = 3; expQ.push_back(ex(0, 0, 1, 0, 0, 1, 0)); end
                1: begin RdE = 3; Rs2D = 3; expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0)); end
                2: begin ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0; expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0)); end
                default: begin ResultSrcE0 = 1; RdE = 12; Rs1D = 12; Rs2D = 4; expQ.push_back(ex(0, 0, 1, 0, 0, 1, 0)); end
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL load_use_case%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            idle();
            case (i)
                0: begin PCSrcE = 1; expQ.push_back(ex(0, 0, 0, 0, 1, 1, 0)); end
                1: expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0));
                default: begin PCSrcE = 1; ResultSrcE0 = 1; RdE = 6; Rs1D = 6; expQ.push_back(ex(0, 0, 1, 0, 1, 1, 0)); end
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch_case%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            idle();
            MemReqM = 1;
            case (i)
                0: expQ.push_back(ex(0, 0, 1, 1, 0, 0, 0));
                1: begin PCSrcE = 1; expQ.push_back(ex(0, 0, 1, 1, 0, 0, 0)); end
                2: expQ.push_back(ex(0, 0, 1, 1, 0, 0, 0));
                3: begin MemReadyM = 1; expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0)); end
                4: begin MemReadyM = 1; expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0)); end
                default: begin MemReqM = 0; PCSrcE = 1; expQ.push_back(ex(0, 0, 0, 0, 1, 1, 0)); end
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL mem_wait_cycle%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 9; i++) begin
            idle();
            MemReqM = 1;
            case (i)
                0, 1, 2, 3: expQ.push_back(ex(0, 0, 1, 1, 0, 0, 0));
                4, 5: expQ.push_back(ex(0, 0, 1, 1, 0, 0, 1));
                6: begin MemReadyM = 1; expQ.push_back(ex(0, 0, 1, 1, 0, 0, 1)); end
                7: begin MemReadyM = 1; PCSrcE = 1; rst = 0; expQ.push_back(12'd0); end
                default: begin MemReqM = 0; rst = 1; expQ.push_back(12'd0); end
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL timeout_cycle%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin MemReqM = 1; expQ.push_back(ex(0, 0, 1, 1, 0, 0, 0)); end
                1: begin MemReqM = 1; rst = 0; expQ.push_back(12'd0); end
                // With no request and no ready, only MWAIT would still stall.
                2: begin rst = 1; expQ.push_back(12'd0); end
                default: expQ.push_back(12'd0);
            endcase
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_mid_wait_cycle%0d got %b want %b", i, obs, e); end
            nextCycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 0;
        idle();
        nextCycle();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
